// File: rtl/ofdm_seq_pkg.sv
// Shared types and default sizing for the OFDM frame sequencer.
// Frame geometry defaults and the sequencer state encoding.
package ofdm_seq_pkg;

  localparam int SEQ_FRAME_LEN = 16;
  localparam int SEQ_IN_CH     = 2;
  localparam int SEQ_N         = SEQ_IN_CH * SEQ_FRAME_LEN;
  localparam int SEQ_AW        = $clog2(SEQ_N);

  typedef enum logic [2:0] {
    IDLE,
    START,
    FEED,
    DRAIN,
    DONE,
    ERR
  } seq_state_e;

endpackage

// File: rtl/seq_frame_ram.sv
// One-write / one-read frame buffer with a registered read port.
// Contents are not reset; only the read register is.
module seq_frame_ram #(
  parameter int DW    = 16,
  parameter int AW    = 5,
  parameter int DEPTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];

  // storage array, survives reset
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // registered read, one cycle latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_o <= '0;
    else     rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/ofdm_frame_sequencer.sv
// Host-side frame sequencer for the cwgan_gp_top generator (inference).
// Optional SEQ_CHECKSUM_EN adds an XOR checksum of captured samples.
module ofdm_frame_sequencer
  import ofdm_seq_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int FRAME_LEN      = SEQ_FRAME_LEN,
  parameter int IN_CH          = SEQ_IN_CH,
  parameter int TIMEOUT_CYCLES = 20000,
  localparam int N  = IN_CH * FRAME_LEN,
  localparam int AW = $clog2(N)
) (
`ifdef SEQ_CHECKSUM_EN
  output logic [DATA_WIDTH-1:0] checksum,
`endif
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  host_wr_en,
  input  logic [AW-1:0]         host_wr_addr,
  input  logic [DATA_WIDTH-1:0] host_wr_data,
  input  logic                  host_go,
  input  logic [AW-1:0]         host_rd_addr,
  output logic [DATA_WIDTH-1:0] host_rd_data,
  output logic                  busy,
  output logic                  frame_done,
  output logic [AW:0]           out_count,
  output logic                  short_err,
  output logic                  timeout_err,
  output logic                  core_start,
  output logic                  core_mode,
  input  logic                  core_done,
  output logic [DATA_WIDTH-1:0] deg_data,
  output logic                  deg_valid,
  input  logic                  deg_ready,
  input  logic [DATA_WIDTH-1:0] recon_data,
  input  logic                  recon_valid,
  output logic                  recon_ready
);

  localparam int          WW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [AW:0] N_W     = (AW+1)'(N);
  localparam logic [AW:0] LAST_W  = (AW+1)'(N - 1);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);

  seq_state_e    st_q;
  logic          start_q, dv_q, rr_q, busy_q;
  logic          done_q, short_q, tmo_q;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [WW-1:0] wdog_q;
  logic          deg_fire, rec_fire, rec_wr;
  logic          idle_c, wd_exp, in_we;

  assign in_we = host_wr_en & ~busy_q;

  // handshake decode and next pointer/count values
  always_comb begin
    deg_fire = dv_q & deg_ready;
    rec_fire = rr_q & recon_valid;
    rec_wr   = rec_fire & (cnt_q != N_W);
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, deg_fire};
    cnt_d    = cnt_q + {{AW{1'b0}}, rec_wr};
    idle_c   = ~deg_fire & ~rec_fire;
    wd_exp   = idle_c & (wdog_q == WD_LAST);
  end

  seq_frame_ram #(
    .DW(DATA_WIDTH), .AW(AW), .DEPTH(N)
  ) u_in_ram (
    .clk(clk), .rst(rst),
    .we_i(in_we), .waddr_i(host_wr_addr),
    .wdata_i(host_wr_data),
    .raddr_i(rd_ptr_d[AW-1:0]),
    .rdata_o(deg_data)
  );

  seq_frame_ram #(
    .DW(DATA_WIDTH), .AW(AW), .DEPTH(N)
  ) u_res_ram (
    .clk(clk), .rst(rst),
    .we_i(rec_wr), .waddr_i(cnt_q[AW-1:0]),
    .wdata_i(recon_data),
    .raddr_i(host_rd_addr),
    .rdata_o(host_rd_data)
  );

  // frame sequencing FSM with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q     <= IDLE;
      start_q  <= 1'b0;
      dv_q     <= 1'b0;
      rr_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      short_q  <= 1'b0;
      tmo_q    <= 1'b0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      wdog_q   <= '0;
    end else begin
      start_q <= 1'b0;
      done_q  <= 1'b0;
      unique case (st_q)
        IDLE: begin
          if (host_go) begin
            st_q     <= START;
            start_q  <= 1'b1;
            busy_q   <= 1'b1;
            short_q  <= 1'b0;
            tmo_q    <= 1'b0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
          end
        end
        START: begin
          st_q   <= FEED;
          dv_q   <= 1'b1;
          rr_q   <= 1'b1;
          wdog_q <= '0;
        end
        FEED, DRAIN: begin
          rd_ptr_q <= rd_ptr_d;
          cnt_q    <= cnt_d;
          wdog_q   <= idle_c ? wdog_q + 1'b1 : '0;
          if (core_done) begin
            st_q    <= DONE;
            done_q  <= 1'b1;
            short_q <= (cnt_d != N_W);
            dv_q    <= 1'b0;
            rr_q    <= 1'b0;
          end else if (wd_exp) begin
            st_q  <= ERR;
            tmo_q <= 1'b1;
            dv_q  <= 1'b0;
            rr_q  <= 1'b0;
          end else if (st_q == FEED && deg_fire &&
                       rd_ptr_q == LAST_W) begin
            st_q   <= DRAIN;
            dv_q   <= 1'b0;
            wdog_q <= '0;
          end
        end
        DONE, ERR: begin
          st_q   <= IDLE;
          busy_q <= 1'b0;
        end
        default: st_q <= IDLE;
      endcase
    end
  end

`ifdef SEQ_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] csum_q;

  // running XOR of every captured recon sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        csum_q <= '0;
    else if (st_q == IDLE && host_go) csum_q <= '0;
    else if (rec_wr)                csum_q <= csum_q ^ recon_data;
  end

  assign checksum = csum_q;
`endif

  assign core_start  = start_q;
  assign core_mode   = 1'b0;
  assign deg_valid   = dv_q;
  assign recon_ready = rr_q;
  assign busy        = busy_q;
  assign frame_done  = done_q;
  assign out_count   = cnt_q;
  assign short_err   = short_q;
  assign timeout_err = tmo_q;

endmodule

// File: tb/tb_ofdm_frame_sequencer.sv
// Randomized bench for ofdm_frame_sequencer with a queue-level
// generator model and frame/result buffer reference arrays.
module tb_ofdm_frame_sequencer;

  localparam int DW  = 16;
  localparam int N   = 32;
  localparam int AW  = 5;
  localparam int TMO = 50;
  localparam int MAXC = 400;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          host_wr_en = 1'b0;
  logic [AW-1:0] host_wr_addr = '0;
  logic [DW-1:0] host_wr_data = '0;
  logic          host_go = 1'b0;
  logic [AW-1:0] host_rd_addr = '0;
  logic [DW-1:0] host_rd_data;
  logic          busy, frame_done, short_err, timeout_err;
  logic [AW:0]   out_count;
  logic          core_start, core_mode;
  logic          core_done = 1'b0;
  logic [DW-1:0] deg_data;
  logic          deg_valid;
  logic          deg_ready = 1'b0;
  logic [DW-1:0] recon_data = '0;
  logic          recon_valid = 1'b0;
  logic          recon_ready;

  always #5 clk = ~clk;

  ofdm_frame_sequencer #(
    .DATA_WIDTH(DW), .FRAME_LEN(16), .IN_CH(2),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .host_wr_en(host_wr_en), .host_wr_addr(host_wr_addr),
    .host_wr_data(host_wr_data), .host_go(host_go),
    .host_rd_addr(host_rd_addr), .host_rd_data(host_rd_data),
    .busy(busy), .frame_done(frame_done),
    .out_count(out_count), .short_err(short_err),
    .timeout_err(timeout_err), .core_start(core_start),
    .core_mode(core_mode), .core_done(core_done),
    .deg_data(deg_data), .deg_valid(deg_valid),
    .deg_ready(deg_ready), .recon_data(recon_data),
    .recon_valid(recon_valid), .recon_ready(recon_ready)
  );

  int n_chk = 0;
  int n_fail = 0;
  logic [DW-1:0] in_m  [N];
  logic [DW-1:0] res_m [N];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load(input int kind);
    logic [DW-1:0] d;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      d = (kind == 0) ? DW'(i - 128) : DW'($urandom);
      host_wr_en   = 1'b1;
      host_wr_addr = AW'(i);
      host_wr_data = d;
      in_m[i]      = d;
    end
    @(negedge clk);
    host_wr_en = 1'b0;
  endtask

  task automatic check_res(input string tag);
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      host_rd_addr = AW'(i);
      @(negedge clk);
      chk(tag, host_rd_data, res_m[i]);
    end
  endtask

  // rdy: 0 always ready, 1 ready one of three, 2 never ready
  task automatic run_frame(input int rdy, input int n_rec,
                           input bit early, input bit tmo,
                           input bit scribble, input bit go_wr);
    int cyc, dcnt, acc, sent, fd, f_cs, f_dv, t_tmo, ecnt;
    bit stalled, rpend, dsent;
    logic [DW-1:0] held, d;
    dcnt = 0; acc = 0; sent = 0; fd = 0;
    f_cs = -1; f_dv = -1; t_tmo = -1;
    stalled = 0; rpend = 0; dsent = 0; held = '0;
    @(negedge clk);
    host_go = 1'b1;
    if (go_wr) begin
      d = DW'($urandom);
      host_wr_en = 1'b1;
      host_wr_addr = AW'(7);
      host_wr_data = d;
      in_m[7] = d;
    end
    cyc = 0;
    @(negedge clk);
    host_go = 1'b0;
    host_wr_en = 1'b0;
    cyc = 1;
    while (cyc < MAXC) begin
      if (core_start && f_cs < 0) f_cs = cyc;
      if (deg_valid && f_dv < 0) f_dv = cyc;
      if (timeout_err && t_tmo < 0) t_tmo = cyc;
      if (frame_done) fd++;
      if (stalled) begin
        chk("deg_hold_valid", deg_valid, 1);
        chk("deg_hold_data", deg_data, held);
      end
      if (!busy) break;
      core_done = 1'b0;
      if (!dsent && !tmo && acc == n_rec && (early || dcnt == N)) begin
        core_done = 1'b1;
        dsent = 1;
        recon_valid = 1'b0;
        rpend = 0;
      end
      case (rdy)
        0: deg_ready = 1'b1;
        1: deg_ready = (cyc % 3 == 0);
        default: deg_ready = 1'b0;
      endcase
      stalled = (rdy == 1) && deg_valid && !deg_ready && !core_done;
      held = deg_data;
      if (deg_valid && deg_ready && !core_done) begin
        if (dcnt < N) chk("deg_order", deg_data, in_m[dcnt]);
        else chk("deg_extra", dcnt + 1, N);
        dcnt++;
      end
      if (!rpend && !dsent) begin
        recon_valid = 1'b0;
        if (sent < n_rec && $urandom_range(1, 0) == 1) begin
          recon_valid = 1'b1;
          recon_data = DW'($urandom);
          sent++;
        end
      end
      if (recon_valid && recon_ready) begin
        if (acc < N) res_m[acc] = recon_data;
        acc++;
        rpend = 0;
      end else begin
        rpend = recon_valid;
      end
      if (scribble) begin
        host_wr_en = 1'b1;
        host_wr_addr = AW'($urandom);
        host_wr_data = DW'($urandom);
      end
      @(negedge clk);
      cyc++;
    end
    deg_ready = 1'b0;
    recon_valid = 1'b0;
    core_done = 1'b0;
    host_wr_en = 1'b0;
    ecnt = (acc < N) ? acc : N;
    chk("busy_drop", cyc < MAXC, 1);
    chk("start_latency", f_cs, 1);
    chk("deg_valid_latency", f_dv, 2);
    chk("out_count", out_count, ecnt);
    chk("frame_done_pulses", fd, tmo ? 0 : 1);
    chk("short_err", short_err, !tmo && acc < N);
    chk("timeout_err", timeout_err, tmo);
    chk("busy_low", busy, 0);
    if (!tmo && !early) chk("deg_count", dcnt, N);
    if (tmo) chk("timeout_cycle", t_tmo >= 48 && t_tmo <= 56, 1);
    check_res("result_buf");
  endtask

  initial begin
    for (int i = 0; i < N; i++) res_m[i] = '0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_deg_valid", deg_valid, 0);
    chk("rst_recon_ready", recon_ready, 0);
    chk("rst_core_start", core_start, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_out_count", out_count, 0);
    chk("rst_flags", {short_err, timeout_err}, 0);
    chk("rst_core_mode", core_mode, 0);
    rst = 1'b0;

    load(0);
    run_frame(0, 32, 0, 0, 0, 0);
    load(1);
    run_frame(1, 32, 0, 0, 0, 1);
    run_frame(0, 40, 0, 0, 1, 0);
    run_frame(1, 20, 1, 0, 0, 0);
    run_frame(2, 0, 0, 1, 0, 0);
    run_frame(0, 32, 0, 0, 0, 0);

    load(1);
    @(negedge clk);
    host_go = 1'b1;
    @(negedge clk);
    host_go = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_deg_valid", deg_valid, 1);
    rst = 1'b1;
    #1;
    chk("arst_deg_valid", deg_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_core_start", core_start, 0);
    chk("arst_recon_ready", recon_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    run_frame(0, 32, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
